i2c_target: RTL and testbench
=============================

# i2c_target

I2C target (slave) endpoint, the responder counterpart of the bus initiator in the i2cbus plugin. It samples SCL/SDA in the system clock domain and detects START, repeated START and STOP. It matches a fixed 7-bit address, collects written bytes into a 32-bit register and returns a 32-bit register on reads. It sits between the FPGA I2C pins and plugin fabric logic, so the design can be addressed by an external I2C controller.

## Interface
- ADDR, 7'h42, 7-bit target address matched in the address phase
- clk  input  1  system clock; must be ≥ 20× SCL frequency
- rst  input  1  synchronous, active-high reset
- scl  input  1  I2C clock from controller; target never drives SCL
- sda  inout  1  open-drain data; driven low only, otherwise high-Z
- set_data_out  input  32  read data; byte 0 sent is [31:24]
- data_in  output  32  received write bytes, newest in [7:0]
- rx_bytes  output  3  bytes received in the last write transaction, saturates at 4
- rx_valid  output  1  one-clk pulse at end of a write transaction
- tx_done  output  1  one-clk pulse at end of a read transaction
- busy  output  1  high from address match until STOP or START

## Operation
- Input path: scl/sda pass through a 2-FF synchronizer, then a 3-sample majority filter. Edges are detected on the filtered signals.
- START: sda_f falls while scl_f is high. STOP: sda_f rises while scl_f is high. Both are honoured in every state, including during reset recovery.
- Bits are sampled on the scl_f rising edge. The target changes its SDA drive only on the cycle after the scl_f falling edge.
- States and transitions:
  - IDLE: no transaction in progress.
  - ADDR: shifts 8 bits, MSB first. If {ADDR, rw} matches, go to ADDR_ACK. On mismatch, go to IGNORE.
  - ADDR_ACK: drive SDA low for one SCL bit; busy←1. On rw=1, latch set_data_out into the tx shift register, then go to READ. On rw=0, clear the byte counter, then go to WRITE.
  - WRITE: shift 8 bits. On the 8th bit: data_in←{data_in[23:0], byte}; rx_bytes←min(rx_bytes+1, 4). Then go to WRITE_ACK.
  - WRITE_ACK: drive ACK low for one bit, then return to WRITE. Every byte is ACKed; more than 4 bytes keep shifting through data_in.
  - READ: drive tx[31] as the bit value (release SDA for 1, drive low for 0); shift tx left, filling with 1s. After 4 bytes the line sends 0xFF.
  - READ_ACK: release SDA and sample the controller's ACK. ACK (0): go to READ. NACK (1): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Any START goes to ADDR. Any STOP goes to IDLE.
- End of transaction (STOP, or repeated START while busy):
  - busy←0.
  - After a write with rx_bytes>0: pulse rx_valid.
  - After a read: pulse tx_done.
  - rx_bytes and data_in hold until the next write address match, which clears rx_bytes only.
- A START or STOP in mid-byte aborts the byte, releases SDA the next clk, and discards the partial byte.

## Timing
- Pin-to-decision latency is 3 clk (2 sync + 1 filter). Edge detection adds 1 more.
- SDA drive update occurs 1 clk after the detected scl_f fall. This gives hold time of at least 4 clk after the pin-level fall.
- ACK drive: asserted after the 8th bit's SCL fall, released after the 9th SCL fall.
- rx_valid and tx_done are asserted for exactly 1 clk, 1 clk after STOP/START detection.
- Reset values: sda high-Z, data_in=0, rx_bytes=0, rx_valid=0, tx_done=0, busy=0, state IDLE.
- Reset asserted mid-transfer releases SDA on the next clk edge. No pulses are emitted.

## Configuration
- I2C_TARGET_GENCALL_EN defined: address 7'h00 with rw=0 (general call) is also ACKed and handled exactly like a write to ADDR. Address 7'h00 with rw=1 goes to IGNORE.
- I2C_TARGET_GENCALL_EN undefined: 7'h00 is not matched (NACK, IGNORE). This is the default.

## Test plan
- Write 2 bytes: START, 0x84 (0x42 W), 0xAB, 0xCD, STOP. Required: 3 ACKs; data_in=32'h0000ABCD; rx_bytes=2; one rx_valid pulse; busy low after STOP.
- Read 4 bytes: set_data_out=32'h12345678; START, 0x85, read with ACK,ACK,ACK,NACK, STOP. Required: bytes 0x12,0x34,0x56,0x78 on SDA; one tx_done pulse.
- Address mismatch: START, 0x86 (0x43 W), 0x55, STOP. Required: SDA never driven; data_in unchanged; no pulses.
- Repeated start: write 0x11 then START, 0x85, read 1 byte with NACK, STOP. Required: rx_valid pulse at repeated START with rx_bytes=1; tx_done pulse at STOP.
- Abort and reset: rst asserted during the 4th bit of a read byte 0x00. Required: SDA released the next clk; all outputs at reset values; the next write 0x84,0x7E gives data_in=32'h0000007E.
- GENCALL: START, 0x00, 0x99, STOP. With I2C_TARGET_GENCALL_EN: ACKs, data_in[7:0]=0x99, rx_valid pulse. Without it: NACK, no pulse.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: I2C target endpoint at a fixed 7-bit address; write bytes collect into data_in, reads return set_data_out MSB first.
// Latency: pin to filtered decision 3 clk, edge detect +1 clk; SDA drive changes 1 clk after a detected SCL fall; pulses 1 clk after STOP/START.
// Backpressure: none, SCL is never stretched and every write byte is ACKed. Build option I2C_TARGET_GENCALL_EN also ACKs general-call writes.
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    input  logic [31:0] set_data_out,
    output logic [31:0] data_in,
    output logic [2:0]  rx_bytes,
    output logic        rx_valid,
    output logic        tx_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WRITE,
        S_WRITE_ACK,
        S_READ,
        S_READ_ACK,
        S_IGNORE
    } state_t;

    state_t      state_q;
    state_t      state_d;

    // Input conditioning: two-stage synchronizer, three-sample history, majority result, previous filtered value.
    logic [1:0]  scl_sync;
    logic [1:0]  sda_sync;
    logic [1:0]  scl_hist;
    logic [1:0]  sda_hist;
    logic        scl_f;
    logic        sda_f;
    logic        scl_f_q;
    logic        sda_f_q;

    logic        scl_rise;
    logic        scl_fall;
    logic        start_det;
    logic        stop_det;
    logic        bus_evt;

    logic [3:0]  bit_cnt;
    logic        byte_done;
    logic        counting;
    logic [7:0]  shift_q;
    logic [7:0]  rx_byte;
    logic [31:0] tx_sr;
    logic        rw_q;
    logic        nack_q;
    logic        addr_hit;

    logic        drive_q;
    logic        drive_d;
    logic        rx_valid_d;
    logic        tx_done_d;

    // Open drain: only ever pull low, otherwise let the bus pull-up win.
    assign sda = drive_q ? 1'b0 : 1'bz;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Synchronize and filter the pins. These flops stay out of reset so the filtered view tracks the
    // bus through reset, and a START/STOP right after reset release is seen without a false edge.
    always_ff @(posedge clk) begin
        scl_sync <= {scl_sync[0], scl};
        sda_sync <= {sda_sync[0], sda};
        scl_hist <= {scl_hist[0], scl_sync[1]};
        sda_hist <= {sda_hist[0], sda_sync[1]};
        scl_f    <= maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
        sda_f    <= maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
        scl_f_q  <= scl_f;
        sda_f_q  <= sda_f;
    end

    assign scl_rise  = scl_f & ~scl_f_q;
    assign scl_fall  = ~scl_f & scl_f_q;
    // SDA moving while SCL is stably high is a bus condition, never data.
    assign start_det = scl_f & scl_f_q & sda_f_q & ~sda_f;
    assign stop_det  = scl_f & scl_f_q & ~sda_f_q & sda_f;
    assign bus_evt   = start_det | stop_det;

    assign byte_done = (bit_cnt == 4'd8);
    assign counting  = ((state_q == S_ADDR) || (state_q == S_WRITE) || (state_q == S_READ)) && !byte_done;
    assign rx_byte   = {shift_q[6:0], sda_f};

    // Address decode on the completed address byte {addr, rw}.
    always_comb begin
        addr_hit = (shift_q == {ADDR, 1'b0}) || (shift_q == {ADDR, 1'b1});
`ifdef I2C_TARGET_GENCALL_EN
        // General call is write-only; 7'h00 with rw=1 still falls to IGNORE.
        if (shift_q == 8'h00) begin
            addr_hit = 1'b1;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: bus conditions win in every state; otherwise phases advance on SCL falls.
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = S_ADDR;
        end else if (stop_det) begin
            state_d = S_IDLE;
        end else if (scl_fall) begin
            case (state_q)
                S_ADDR:      if (byte_done) state_d = addr_hit ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK:  state_d = rw_q ? S_READ : S_WRITE;
                S_WRITE:     if (byte_done) state_d = S_WRITE_ACK;
                S_WRITE_ACK: state_d = S_WRITE;
                S_READ:      if (byte_done) state_d = S_READ_ACK;
                S_READ_ACK:  state_d = nack_q ? S_IGNORE : S_READ;
                default:     state_d = state_q;
            endcase
        end
    end

    // Outputs: next SDA drive (only ever updated off an SCL fall or a bus condition) and end-of-transaction pulses.
    always_comb begin
        drive_d    = drive_q;
        rx_valid_d = 1'b0;
        tx_done_d  = 1'b0;
        if (bus_evt) begin
            drive_d = 1'b0;
            if (busy) begin
                rx_valid_d = !rw_q && (rx_bytes != 3'd0);
                tx_done_d  = rw_q;
            end
        end else if (scl_fall) begin
            case (state_q)
                S_ADDR:      drive_d = byte_done && addr_hit;
                S_ADDR_ACK:  drive_d = rw_q ? ~set_data_out[31] : 1'b0;
                S_WRITE:     drive_d = byte_done;
                S_WRITE_ACK: drive_d = 1'b0;
                S_READ:      drive_d = byte_done ? 1'b0 : ~tx_sr[30];
                S_READ_ACK:  drive_d = nack_q ? 1'b0 : ~tx_sr[31];
                default:     drive_d = 1'b0;
            endcase
        end
    end

    // Datapath: bit counting, shift registers, received-data capture and transaction flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            drive_q  <= 1'b0;
            rx_valid <= 1'b0;
            tx_done  <= 1'b0;
            bit_cnt  <= 4'd0;
            shift_q  <= 8'h00;
            tx_sr    <= 32'h0;
            rw_q     <= 1'b0;
            nack_q   <= 1'b0;
            busy     <= 1'b0;
            data_in  <= 32'h0;
            rx_bytes <= 3'd0;
        end else begin
            drive_q  <= drive_d;
            rx_valid <= rx_valid_d;
            tx_done  <= tx_done_d;

            // Any phase change or bus condition restarts the byte, which also discards a partial byte.
            if (bus_evt || (state_d != state_q)) begin
                bit_cnt <= 4'd0;
            end else if (scl_rise && counting) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (scl_rise && counting) begin
                shift_q <= rx_byte;
            end

            if (bus_evt) begin
                busy <= 1'b0;
            end else if ((state_q == S_ADDR) && (state_d == S_ADDR_ACK)) begin
                busy <= 1'b1;
                rw_q <= shift_q[0];
                // A new write starts a fresh byte count; data_in keeps its history.
                if (!shift_q[0]) begin
                    rx_bytes <= 3'd0;
                end
            end

            // Commit a write byte on its 8th sampled bit.
            if (!bus_evt && (state_q == S_WRITE) && scl_rise && (bit_cnt == 4'd7)) begin
                data_in <= {data_in[23:0], rx_byte};
                if (rx_bytes != 3'd4) begin
                    rx_bytes <= rx_bytes + 3'd1;
                end
            end

            // Read data: load at the end of the address ACK, then shift in 1s so exhausted data reads 0xFF.
            if ((state_q == S_ADDR_ACK) && (state_d == S_READ)) begin
                tx_sr <= set_data_out;
            end else if (!bus_evt && (state_q == S_READ) && scl_fall) begin
                tx_sr <= {tx_sr[30:0], 1'b1};
            end

            if ((state_q == S_READ_ACK) && scl_rise) begin
                nack_q <= sda_f;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;

    localparam logic [6:0] ADDR = 7'h42;
    localparam int         Q    = 10;   // quarter SCL period in clk; SCL = clk/40
`ifdef I2C_TARGET_GENCALL_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        sda_low = 1'b0;
    logic [31:0] set_data_out = 32'h0;
    wire         sda;
    logic [31:0] data_in;
    logic [2:0]  rx_bytes;
    logic        rx_valid;
    logic        tx_done;
    logic        busy;

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target #(.ADDR(ADDR)) dut (
        .clk          (clk),
        .rst          (rst),
        .scl          (scl),
        .sda          (sda),
        .set_data_out (set_data_out),
        .data_in      (data_in),
        .rx_bytes     (rx_bytes),
        .rx_valid     (rx_valid),
        .tx_done      (tx_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bus observers, sampled on the falling clk edge.
    int         n_rxv = 0;
    int         n_txd = 0;
    int         n_dut_low = 0;
    logic [2:0] rxb_at_rxv = 3'd0;
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            n_rxv++;
            rxb_at_rxv = rx_bytes;
        end
        if (tx_done === 1'b1) n_txd++;
        if (!sda_low && sda === 1'b0) n_dut_low++;
    end

    // Reference model: every byte the target has accepted since reset, and the count of the last write.
    logic [7:0] m_hist[$];
    int         m_rxb = 0;
    logic [7:0] wbytes[8];
    int         rxv0 = 0;
    int         txd0 = 0;

    function automatic logic [31:0] exp_data();
        logic [31:0] v = 32'h0;
        int k = m_hist.size();
        for (int i = (k > 4 ? k - 4 : 0); i < k; i++) v = (v << 8) | 32'(m_hist[i]);
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // START from idle, or repeated START when SCL is low.
    task automatic start_cond();
        if (scl == 1'b0) begin
            sda_low = 1'b0; tick(Q);
            scl = 1'b1;     tick(Q);
        end
        sda_low = 1'b1; tick(Q);
        scl = 1'b0;     tick(Q);
    endtask

    task automatic stop_cond();
        sda_low = 1'b1; tick(Q);
        scl = 1'b1;     tick(Q);
        sda_low = 1'b0; tick(Q);
        tick(Q);
    endtask

    // One SCL bit: put b on SDA (1 = release), sample the resolved line mid-high.
    task automatic clock_bit(input logic b, output logic s);
        sda_low = ~b; tick(Q);
        scl = 1'b1;   tick(Q);
        s = sda;      tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(nack, s);
    endtask

    task automatic mark();
        rxv0 = n_rxv;
        txd0 = n_txd;
    endtask

    task automatic write_txn(input string tag, input logic [6:0] a, input int n);
        logic ack;
        logic hit;
        hit = (a == ADDR) || (GC && a == 7'h00);
        start_cond();
        send_byte({a, 1'b0}, ack);
        check({tag, "_addr_ack"}, 32'(ack), 32'(!hit));
        for (int i = 0; i < n; i++) begin
            send_byte(wbytes[i], ack);
            check({tag, "_data_ack"}, 32'(ack), 32'(!hit));
            if (hit) m_hist.push_back(wbytes[i]);
        end
        if (hit) m_rxb = (n > 4) ? 4 : n;
        check({tag, "_busy_mid"}, 32'(busy), 32'(hit));
    endtask

    task automatic read_txn(input string tag, input int n);
        logic       ack;
        logic [7:0] d;
        logic [7:0] e;
        start_cond();
        send_byte({ADDR, 1'b1}, ack);
        check({tag, "_addr_ack"}, 32'(ack), 32'h0);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, d);
            e = (i < 4) ? 8'(set_data_out >> (8 * (3 - i))) : 8'hFF;
            check({tag, "_byte"}, 32'(d), 32'(e));
        end
    endtask

    task automatic finish_txn(input string tag, input int e_rxv, input int e_txd);
        stop_cond();
        tick(5);
        check({tag, "_data_in"},  data_in, exp_data());
        check({tag, "_rx_bytes"}, 32'(rx_bytes), 32'(m_rxb));
        check({tag, "_rx_valid"}, 32'(n_rxv - rxv0), 32'(e_rxv));
        check({tag, "_tx_done"},  32'(n_txd - txd0), 32'(e_txd));
        check({tag, "_busy_end"}, 32'(busy), 32'h0);
    endtask

    initial begin
        logic       ack;
        logic       s;
        int         low0;
        int         kind;
        int         n;
        logic [6:0] a;

        // Reset state
        rst = 1'b1; tick(10);
        rst = 1'b0; tick(10);
        check("rst_data_in",  data_in, 32'h0);
        check("rst_rx_bytes", 32'(rx_bytes), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_tx_done",  32'(tx_done), 32'h0);
        check("rst_busy",     32'(busy), 32'h0);
        check("rst_sda",      32'(sda), 32'h1);

        // Two-byte write
        mark();
        wbytes[0] = 8'hAB; wbytes[1] = 8'hCD;
        write_txn("wr2", ADDR, 2);
        finish_txn("wr2", 1, 0);
        check("wr2_abs", data_in, 32'h0000ABCD);

        // Four-byte read, NACK on the last
        set_data_out = 32'h12345678;
        mark();
        read_txn("rd4", 4);
        finish_txn("rd4", 0, 1);

        // Address mismatch: SDA must never be pulled by the target
        low0 = n_dut_low;
        mark();
        wbytes[0] = 8'h55;
        write_txn("nomatch", 7'h43, 1);
        finish_txn("nomatch", 0, 0);
        check("nomatch_sda_driven", 32'(n_dut_low - low0), 32'h0);

        // Write then repeated START into a one-byte read
        mark();
        wbytes[0] = 8'h11;
        write_txn("rs_wr", ADDR, 1);
        set_data_out = $urandom;
        read_txn("rs_rd", 1);
        check("rs_rxv_at_rstart", 32'(n_rxv - rxv0), 32'h1);
        check("rs_rxb_at_pulse",  32'(rxb_at_rxv), 32'h1);
        check("rs_txd_before_stop", 32'(n_txd - txd0), 32'h0);
        finish_txn("rs", 1, 1);

        // Long write: count saturates, data keeps shifting
        mark();
        for (int i = 0; i < 6; i++) wbytes[i] = 8'($urandom);
        write_txn("wr6", ADDR, 6);
        finish_txn("wr6", 1, 0);

        // General call
        mark();
        wbytes[0] = 8'h99;
        write_txn("gencall", 7'h00, 1);
        finish_txn("gencall", GC ? 1 : 0, 0);

        // Reset in the 4th bit of a read byte 0x00
        set_data_out = 32'h0;
        mark();
        start_cond();
        send_byte({ADDR, 1'b1}, ack);
        check("rstmid_addr_ack", 32'(ack), 32'h0);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
        sda_low = 1'b0; tick(Q);
        scl = 1'b1;     tick(3);
        check("rstmid_driving", 32'(sda), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_sda_released", 32'(sda), 32'h1);
        check("rstmid_data_in",  data_in, 32'h0);
        check("rstmid_rx_bytes", 32'(rx_bytes), 32'h0);
        check("rstmid_busy",     32'(busy), 32'h0);
        check("rstmid_rx_valid", 32'(rx_valid), 32'h0);
        check("rstmid_tx_done",  32'(tx_done), 32'h0);
        tick(5);
        rst = 1'b0; tick(10);
        scl = 1'b0; tick(Q);
        stop_cond();
        check("rstmid_no_rxv", 32'(n_rxv - rxv0), 32'h0);
        check("rstmid_no_txd", 32'(n_txd - txd0), 32'h0);
        m_hist.delete();
        m_rxb = 0;
        mark();
        wbytes[0] = 8'h7E;
        write_txn("post_rst", ADDR, 1);
        finish_txn("post_rst", 1, 0);
        check("post_rst_abs", data_in, 32'h0000007E);

        // Randomized transactions against the model
        for (int t = 0; t < 8; t++) begin
            kind = $urandom_range(0, 2);
            mark();
            if (kind == 0) begin
                n = $urandom_range(0, 6);
                for (int i = 0; i < n; i++) wbytes[i] = 8'($urandom);
                write_txn("rnd_wr", ADDR, n);
                finish_txn("rnd_wr", (n > 0) ? 1 : 0, 0);
            end else if (kind == 1) begin
                n = $urandom_range(1, 6);
                set_data_out = $urandom;
                read_txn("rnd_rd", n);
                finish_txn("rnd_rd", 0, 1);
            end else begin
                n = $urandom_range(0, 3);
                a = 7'($urandom_range(1, 127));
                if (a == ADDR) a = 7'h43;
                for (int i = 0; i < n; i++) wbytes[i] = 8'($urandom);
                low0 = n_dut_low;
                write_txn("rnd_nomatch", a, n);
                finish_txn("rnd_nomatch", 0, 0);
                check("rnd_nomatch_sda_driven", 32'(n_dut_low - low0), 32'h0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
